// File: rtl/risc0_exec_sequencer_if.sv
// Run-control bundle between the exec sequencer (master) and the executor / segment writer / host (slave).
// Carries start/config, the step handshake, the flush handshake and the status outputs.
interface risc0_exec_sequencer_if #(
    parameter int CYCLE_W = 64,
    parameter int STEP_W  = 8
);
    logic                start_execution;
    logic [31:0]         segment_threshold;
    logic [31:0]         max_cycles;
    logic                core_step;
    logic                core_step_done;
    logic                core_halt;
    logic                core_fault;
    logic [STEP_W-1:0]   core_step_cycles;
    logic                seg_flush_req;
    logic                seg_flush_last;
    logic                seg_flush_ack;
    logic [31:0]         seg_count;
    logic                busy;
    logic                execution_done;
    logic                execution_error;
    logic [1:0]          error_code;
    logic [CYCLE_W-1:0]  user_cycles;
    logic [CYCLE_W-1:0]  total_cycles;

    modport master (
        input  start_execution, segment_threshold, max_cycles,
        input  core_step_done, core_halt, core_fault, core_step_cycles,
        input  seg_flush_ack,
        output core_step, seg_flush_req, seg_flush_last, seg_count,
        output busy, execution_done, execution_error, error_code,
        output user_cycles, total_cycles
    );

    modport slave (
        output start_execution, segment_threshold, max_cycles,
        output core_step_done, core_halt, core_fault, core_step_cycles,
        output seg_flush_ack,
        input  core_step, seg_flush_req, seg_flush_last, seg_count,
        input  busy, execution_done, execution_error, error_code,
        input  user_cycles, total_cycles
    );
endinterface

// File: rtl/risc0_exec_sequencer.sv
// Run-control sequencer: steps the executor one instruction at a time, accounts cycles, splits segments.
// Latency: start -> core_step next cycle; step_done/ack -> next action next cycle. Flush req held until ack.
module risc0_exec_sequencer #(
    parameter int CYCLE_W = 64,
    parameter int STEP_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    risc0_exec_sequencer_if.master    bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_FLUSH, S_DONE, S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         thr_q, thr_d, max_q, max_d;
    logic [31:0]         seg_user_q, seg_user_d, seg_count_q, seg_count_d;
    logic [CYCLE_W-1:0]  user_q, user_d, total_q, total_d;
    logic                last_q, last_d, done_q, done_d, err_q, err_d;
    logic [1:0]          code_q, code_d;
    logic                step_q, req_q, req_last_q, busy_q;
    logic [CYCLE_W-1:0]  user_add;
    logic [31:0]         seg_add;
    logic                run_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            thr_q       <= '0;
            max_q       <= '0;
            seg_user_q  <= '0;
            seg_count_q <= '0;
            user_q      <= '0;
            total_q     <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= '0;
            step_q      <= 1'b0;
            req_q       <= 1'b0;
            req_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            thr_q       <= thr_d;
            max_q       <= max_d;
            seg_user_q  <= seg_user_d;
            seg_count_q <= seg_count_d;
            user_q      <= user_d;
            total_q     <= total_d;
            last_q      <= last_d;
            done_q      <= done_d;
            err_q       <= err_d;
            code_q      <= code_d;
            // Handshake outputs are decoded from the next state so they are flops, not state decode.
            step_q      <= (state_d == S_ISSUE);
            req_q       <= (state_d == S_FLUSH);
            req_last_q  <= (state_d == S_FLUSH) && last_d;
            busy_q      <= (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_FLUSH);
        end
    end

    always_comb begin
        state_d     = state_q;
        thr_d       = thr_q;
        max_d       = max_q;
        seg_user_d  = seg_user_q;
        seg_count_d = seg_count_q;
        user_d      = user_q;
        total_d     = total_q;
        last_d      = last_q;
        done_d      = done_q;
        err_d       = err_q;
        code_d      = code_q;
        run_busy    = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_FLUSH);
        user_add    = user_q + CYCLE_W'(bus.core_step_cycles);
        seg_add     = seg_user_q + 32'(bus.core_step_cycles);

        if (run_busy) begin
            total_d = total_q + CYCLE_W'(1);
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.start_execution) begin
                    thr_d       = bus.segment_threshold;
                    max_d       = bus.max_cycles;
                    seg_user_d  = '0;
                    seg_count_d = '0;
                    user_d      = '0;
                    total_d     = '0;
                    last_d      = 1'b0;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    code_d      = 2'd0;
                    if (bus.segment_threshold == 32'd0) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        code_d  = 2'd3;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.core_step_done) begin
                    user_d     = user_add;
                    seg_user_d = seg_add;
                    // Halt outranks the cycle limit so a terminating step still completes cleanly.
                    if (bus.core_fault) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end else if (bus.core_halt) begin
                        state_d = S_FLUSH;
                        last_d  = 1'b1;
                    end else if ((max_q != 32'd0) && (user_add > CYCLE_W'(max_q))) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                    end else if (seg_add >= thr_q) begin
                        state_d = S_FLUSH;
                        last_d  = 1'b0;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_FLUSH: begin
                if (bus.seg_flush_ack) begin
                    seg_count_d = seg_count_q + 32'd1;
                    seg_user_d  = '0;
                    if (last_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.core_step       = step_q;
    assign bus.seg_flush_req   = req_q;
    assign bus.seg_flush_last  = req_last_q;
    assign bus.seg_count       = seg_count_q;
    assign bus.busy            = busy_q;
    assign bus.execution_done  = done_q;
    assign bus.execution_error = err_q;
    assign bus.error_code      = code_q;
    assign bus.user_cycles     = user_q;
    assign bus.total_cycles    = total_q;
endmodule

// File: doc/risc0_exec_sequencer.md
# risc0_exec_sequencer

Run-control sequencer for the RISC-V executor in the FPGA build. It accepts a start request and issues single-instruction step enables to the executor core. It accounts user and total cycles, and splits execution into segments at the programmed threshold using a flush handshake with the segment writer. It terminates with done or error on halt, fault or cycle-limit exhaustion, and drives the top-level `execution_done`, `execution_error`, `user_cycles` and `total_cycles` status outputs.

## Interface
- `CYCLE_W`, 64: width of the `user_cycles` and `total_cycles` counters.
- `STEP_W`, 8: width of the per-instruction cycle charge.

Ports, clock and reset first:
- `clk`  in  1  system clock, single domain.
- `rst_n`  in  1  asynchronous active-low reset; deassertion is synchronised externally.
- `start_execution`  in  1  start request; honoured only in IDLE, DONE or ERROR.
- `segment_threshold`  in  32  user cycles per segment; sampled at start.
- `max_cycles`  in  32  user-cycle limit, 0 = unlimited; sampled at start.
- `core_step`  out  1  one-cycle pulse: executor retires exactly one instruction.
- `core_step_done`  in  1  executor retired the stepped instruction.
- `core_halt`  in  1  qualified by `core_step_done`; the instruction was a terminating ecall.
- `core_fault`  in  1  qualified by `core_step_done`; illegal instruction or memory fault.
- `core_step_cycles`  in  STEP_W  user cycles charged for the retired instruction.
- `seg_flush_req`  out  1  segment boundary pending; held until ack.
- `seg_flush_last`  out  1  valid with `seg_flush_req`; this is the final segment.
- `seg_flush_ack`  in  1  segment writer has consumed the boundary.
- `seg_count`  out  32  segments completed in this run.
- `busy`  out  1  high in ISSUE, WAIT and FLUSH.
- `execution_done`  out  1  sticky successful completion.
- `execution_error`  out  1  sticky failure.
- `error_code`  out  2  0 none, 1 fault, 2 max_cycles exceeded, 3 zero threshold.
- `user_cycles`  out  CYCLE_W  accumulated user cycles.
- `total_cycles`  out  CYCLE_W  clocks spent in ISSUE, WAIT and FLUSH.

## Operation
- States are IDLE, ISSUE, WAIT, FLUSH, DONE and ERROR. Reset enters IDLE, and every output resets to 0.
- **IDLE, DONE, ERROR + `start_execution`:**
  - Latch the threshold and limit.
  - Clear `user_cycles`, `total_cycles`, `seg_count`, the internal `seg_user` counter (32-bit), the done/error flags and `error_code`.
  - If the latched threshold is 0, go to ERROR with code 3. Otherwise go to ISSUE.
- **ISSUE:** assert `core_step` for this cycle only, then go to WAIT.
- **WAIT:** `core_step_done` is acted on only here; it is ignored in every other state. On `core_step_done`:
  - Add `core_step_cycles`, zero-extended, to `user_cycles` and `seg_user`.
  - Pick the next state in priority order:
    - `core_fault` → ERROR, code 1.
    - `core_halt` → FLUSH with last=1.
    - max≠0 and new `user_cycles` > max → ERROR, code 2.
    - new `seg_user` ≥ threshold → FLUSH with last=0.
    - Otherwise → ISSUE.
- **FLUSH:** hold `seg_flush_req` and `seg_flush_last` steady until `seg_flush_ack`. On the ack cycle:
  - Increment `seg_count` and clear `seg_user`.
  - Go to DONE if last=1, otherwise to ISSUE.
  - `seg_flush_ack` outside FLUSH is ignored.
- **DONE / ERROR:** flags, counters and `error_code` hold until the next start.
- `start_execution` in ISSUE, WAIT or FLUSH is ignored.
- `total_cycles` increments by 1 on every clock spent in ISSUE, WAIT or FLUSH.
- Counters wrap modulo 2^width; no saturation.
- A halt step that also crosses max_cycles completes as DONE, because halt has priority. The flush for that step is still issued.
- A fault step produces no flush.
- Reset asserted mid-run (any state, including FLUSH with req high) forces all outputs to 0 immediately, without waiting for a clock edge.

## Timing
- All outputs are registered.
- Start accepted at edge N: `busy` and `core_step` are high in cycle N+1.
- `core_step` is high for exactly one cycle per instruction.
- The executor may return `core_step_done` no earlier than the cycle after `core_step`.
- Loop cost per instruction, no boundary: 2 cycles plus executor latency.
- A `core_step_done` sampled at edge M produces an updated `user_cycles` and the next `core_step` or `seg_flush_req` in cycle M+1.
- Ack sampled at edge K drops `seg_flush_req` in cycle K+1 and raises `execution_done` in cycle K+1 for the final segment.
- A zero threshold raises `execution_error` in the cycle after start; `core_step` is never issued.

## Test plan
- **Baseline run.** Threshold 1000, max 10000; four steps of 1 cycle each, done asserted the cycle after `core_step`, halt on step 4; immediate ack. Expect: one flush with last=1, `seg_count`=1, `user_cycles`=4, `execution_done`=1, `error_code`=0.
- **Segment splitting.** Threshold 3, seven 1-cycle steps, halt on step 7. Expect: flushes after steps 3, 6 and 7, with `seg_flush_last` set only on the third; `seg_count`=3.
- **Cycle limit.** Max 5, steps of 2 cycles each, no halt. Expect: ERROR after step 3 with `user_cycles`=6, `error_code`=2, no flush.
- **Fault priority.** Step 2 returns `core_fault` and `core_halt` together. Expect: ERROR with code 1, no `seg_flush_req`.
- **Zero threshold.** Start with threshold 0. Expect: `execution_error` with code 3 in the next cycle, `core_step` never asserted.
- **Ack hold and mid-run reset.** Hold ack low for 20 cycles, then assert `rst_n`=0 while `seg_flush_req`=1. Expect: `seg_flush_req` stays stable while ack is low; at reset all outputs go to 0 immediately; after release, a new start runs the baseline scenario correctly.
